// File: rtl/jio_ports_if.sv
// jio_ports_if: CPU IO control lines plus the per-channel peripheral
// streams of the jio_ports controller. The controller takes the slave
// modport; the CPU/peripheral side (or a bench) takes master.
interface jio_ports_if #(
  parameter int WIDTH = 8,
  parameter int NCHAN = 4,
  parameter int AW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
);
  // CPU side
  logic                         io_s;
  logic                         io_e;
  logic                         io_da;
  logic                         io_io;
  logic [WIDTH-1:0]             bus_in;
  logic [WIDTH-1:0]             bus_out;
  logic                         bus_oe;
  // peripheral side, channel k in row k
  logic [NCHAN-1:0][WIDTH-1:0]  out_data;
  logic [NCHAN-1:0]             out_valid;
  logic [NCHAN-1:0]             out_ready;
  logic [NCHAN-1:0][WIDTH-1:0]  in_data;
  logic [NCHAN-1:0]             in_valid;
  logic [NCHAN-1:0]             in_ready;
  logic [NCHAN-1:0]             ovf;
  logic [AW-1:0]                dev_sel;

  modport slave (
    input  io_s, io_e, io_da, io_io, bus_in, out_ready, in_data, in_valid,
    output bus_out, bus_oe, out_data, out_valid, in_ready, ovf, dev_sel
  );

  modport master (
    output io_s, io_e, io_da, io_io, bus_in, out_ready, in_data, in_valid,
    input  bus_out, bus_oe, out_data, out_valid, in_ready, ovf, dev_sel
  );
endinterface

// File: rtl/jio_ports.sv
// jio_ports: multi-channel IO port controller for the jcscpu IO strobes.
// Each channel owns an output FIFO (CPU -> peripheral) and an input
// holding register (peripheral -> CPU). The CPU selects a channel with an
// address write, then pushes data writes or reads the holding register.
// Optional feature: define JIO_STATUS_EN to enable status reads
// ({ovf, full, hold_full} in bits 2:0) with ovf cleared at the end of one.

// jio_chan: one channel -- output FIFO, input holding register, ovf flag.
module jio_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             hold_clr,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] head,
  output logic             out_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full,
  output logic             full,
  output logic             ovf
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  logic             pop, wr_en, drop, load;

  assign out_valid = (count != '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign pop       = out_valid & out_ready;
  // a full FIFO still takes a push when the head leaves the same cycle
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign head      = mem[rd_ptr];
  assign in_ready  = ~hold_full;
  assign load      = in_valid & in_ready;

  // storage: no reset, contents are only visible through count
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // pointers, occupancy, holding register and overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, pop};
      if (load) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end else if (hold_clr) begin
        hold_full <= 1'b0;
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end
endmodule

module jio_ports #(
  parameter int WIDTH = 8,
  parameter int NCHAN = 4,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  jio_ports_if.slave bus
);
  localparam int AW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic                        io_s_q, io_e_q, rd_q, dev_ok;
  logic                        set_ev, end_e, addr_wr, data_wr;
  logic [AW-1:0]               dev_sel;
  logic [NCHAN-1:0]            push, hold_clr, ovf_clr, hold_full, full;
  logic [NCHAN-1:0][WIDTH-1:0] hold;

  // one event per CPU strobe regardless of how long it is held
  assign set_ev  = bus.io_s & ~io_s_q;
  assign end_e   = ~bus.io_e & io_e_q;
  assign addr_wr = set_ev & bus.io_da & bus.io_io;
  assign data_wr = set_ev & ~bus.io_da & bus.io_io & dev_ok;
  assign bus.dev_sel = dev_sel;

`ifdef JIO_STATUS_EN
  logic st_q;
  // remember a status read so its falling io_e can clear ovf
  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= 1'b0;
    else        st_q <= bus.io_e & bus.io_da & ~bus.io_io;
  end
`endif

  // strobe history, read-cycle flag and device selection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_s_q  <= 1'b0;
      io_e_q  <= 1'b0;
      rd_q    <= 1'b0;
      dev_sel <= '0;
      dev_ok  <= 1'b1;
    end else begin
      io_s_q <= bus.io_s;
      io_e_q <= bus.io_e;
      rd_q   <= bus.io_e & ~bus.io_da & ~bus.io_io;
      if (addr_wr) begin
        dev_sel <= bus.bus_in[AW-1:0];
        dev_ok  <= (bus.bus_in < WIDTH'(NCHAN));
      end
    end
  end

  // per-channel strobes decoded from the selected device
  always_comb begin
    push     = '0;
    hold_clr = '0;
    ovf_clr  = '0;
    push[dev_sel]     = data_wr;
    hold_clr[dev_sel] = end_e & rd_q & dev_ok;
`ifdef JIO_STATUS_EN
    ovf_clr[dev_sel]  = end_e & st_q;
`endif
  end

  // bus drive is purely combinational from the live strobe levels
  always_comb begin
    bus.bus_oe  = 1'b0;
    bus.bus_out = '0;
    if (bus.io_e && !bus.io_io && !bus.io_da) begin
      bus.bus_oe = 1'b1;
      if (dev_ok && hold_full[dev_sel]) bus.bus_out = hold[dev_sel];
    end
`ifdef JIO_STATUS_EN
    else if (bus.io_e && !bus.io_io && bus.io_da) begin
      bus.bus_oe  = 1'b1;
      bus.bus_out = {{(WIDTH-3){1'b0}}, bus.ovf[dev_sel], full[dev_sel],
                     hold_full[dev_sel]};
    end
`endif
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    jio_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[k]),
      .din       (bus.bus_in),
      .out_ready (bus.out_ready[k]),
      .in_valid  (bus.in_valid[k]),
      .in_data   (bus.in_data[k]),
      .hold_clr  (hold_clr[k]),
      .ovf_clr   (ovf_clr[k]),
      .head      (bus.out_data[k]),
      .out_valid (bus.out_valid[k]),
      .in_ready  (bus.in_ready[k]),
      .hold      (hold[k]),
      .hold_full (hold_full[k]),
      .full      (full[k]),
      .ovf       (bus.ovf[k])
    );
  end
endmodule
